// File: rtl/ndata_width_downsizer.sv
// ndata_width_downsizer
//   Splits each 16-element input beat into two 8-element output beats.
//   An accepted input beat is captured into a holding buffer. The low half
//   is emitted first, then the high half. The output is driven only from
//   that buffer.
//
// Optional feature (macro LIBSTF_DWC_SKIP_EMPTY_HALF_EN):
//   When defined, a buffered beat whose keep[15:8] is all zero emits only
//   its low half, and that half carries last. When undefined, both halves
//   are always emitted.
//
// Parameters
//   data_t     element type on both streams
//   IN_WIDTH   elements per input beat  (must be 16)
//   OUT_WIDTH  elements per output beat (must be 8)
//
// Ports
//   clk        clock; all state changes on its rising edge
//   rst        synchronous, active-high reset
//   in_data    input elements          in_keep   per-element keep
//   in_valid   input valid             in_ready  input ready
//   in_last    input end-of-packet
//   out_data   output elements         out_keep  per-element keep
//   out_valid  output valid            out_ready output ready
//   out_last   output end-of-packet
module ndata_width_downsizer #(
    parameter type data_t    = logic [7:0],
    parameter int  IN_WIDTH  = 16,
    parameter int  OUT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  data_t [IN_WIDTH-1:0]   in_data,
    input  logic  [IN_WIDTH-1:0]   in_keep,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output data_t [OUT_WIDTH-1:0]  out_data,
    output logic  [OUT_WIDTH-1:0]  out_keep,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready
);

    if (IN_WIDTH != 16) begin : g_bad_in_width
        $error("ndata_width_downsizer: IN_WIDTH must be 16");
    end
    if (OUT_WIDTH != 8) begin : g_bad_out_width
        $error("ndata_width_downsizer: OUT_WIDTH must be 8");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOW   = 2'd1,
        HIGH  = 2'd2
    } state_t;

    state_t                state;
    data_t [IN_WIDTH-1:0]  buf_data;
    logic  [IN_WIDTH-1:0]  buf_keep;
    logic                  buf_last;

    logic skip_high;
    logic final_half;
    logic accept;

`ifdef LIBSTF_DWC_SKIP_EMPTY_HALF_EN
    assign skip_high = (buf_keep[IN_WIDTH-1:OUT_WIDTH] == '0);
`else
    assign skip_high = 1'b0;
`endif

    // The low half is always emitted, even with zero keep. This keeps last
    // from being lost when the whole beat is empty.
    assign final_half = (state == HIGH) || ((state == LOW) && skip_high);

    // Accept a new beat into an empty buffer, or in the same cycle that the
    // final half drains. This gives back-to-back beats with no bubble.
    // Reset blocks the handshake so nothing is captured during a reset cycle.
    assign in_ready = !rst && ((state == EMPTY) || (final_half && out_ready));
    assign accept   = in_valid && in_ready;

    assign out_valid = (state != EMPTY);
    assign out_last  = buf_last && final_half;

    always_comb begin
        out_data = buf_data[OUT_WIDTH-1:0];
        out_keep = buf_keep[OUT_WIDTH-1:0];
        if (state == HIGH) begin
            out_data = buf_data[IN_WIDTH-1:OUT_WIDTH];
            out_keep = buf_keep[IN_WIDTH-1:OUT_WIDTH];
        end
    end

    // The buffer needs no reset. It is meaningful only while state != EMPTY,
    // and it is refilled on every accepted beat.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_data <= in_data;
            buf_keep <= in_keep;
            buf_last <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) state <= LOW;
                end
                LOW: begin
                    if (out_ready) begin
                        if (!final_half) state <= HIGH;
                        else             state <= accept ? LOW : EMPTY;
                    end
                end
                HIGH: begin
                    if (out_ready) state <= accept ? LOW : EMPTY;
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: doc/ndata_width_downsizer.md
NDATA_WIDTH_DOWNSIZER -- requirements
Module: NDataWidthDownsizer

Interface
REQ-001 SHALL have parameter data_t, default none (type), element type carried on both streams.
REQ-002 SHALL have parameter IN_WIDTH, default 16, elements per input beat; elaboration SHALL fail unless IN_WIDTH == 16.
REQ-003 SHALL have parameter OUT_WIDTH, default 8, elements per output beat; elaboration SHALL fail unless OUT_WIDTH == 8.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in  ndata_i.s  data_t x IN_WIDTH, 16-bit keep, valid/ready/last  wide input stream.
REQ-007 SHALL have port out  ndata_i.m  data_t x OUT_WIDTH, 8-bit keep, valid/ready/last  narrow output stream.

Function
REQ-008 SHALL register each accepted in beat (data, keep, last) into a 16-element holding buffer; out SHALL be driven only from that buffer, never combinationally from in.
REQ-009 SHALL use states EMPTY, LOW and HIGH: EMPTY = buffer empty; LOW = emitting elements [7:0]; HIGH = emitting elements [15:8].
REQ-010 SHALL set out.valid = 1 in LOW and HIGH and 0 in EMPTY.
REQ-011 SHALL drive out.data/out.keep with buffer[7:0]/keep[7:0] in LOW and buffer[15:8]/keep[15:8] in HIGH.
REQ-012 SHALL treat the current half as final when the state is HIGH, or when the state is LOW and the high half is skipped (REQ-021).
REQ-013 SHALL assert out.last only on the final half of a buffered beat whose last = 1.
REQ-014 SHALL set in.ready = (state == EMPTY) || (final half && out.ready).
REQ-015 SHALL handle EMPTY with in.valid as: capture, go to LOW.
REQ-016 SHALL handle LOW with out.ready and a non-final half as: go to HIGH.
REQ-017 SHALL handle a final half with out.ready as: go to LOW if in.valid (capture the new beat in the same cycle), else go to EMPTY.
REQ-018 SHALL hold state, buffer and out signals stable while out.valid && !out.ready.
REQ-019 SHALL have a latency of 1 cycle from in acceptance to the first out.valid.
REQ-020 SHALL sustain full output throughput (one out beat per cycle) when in.valid is held high and out.ready is high; no bubble between input beats.

Reset
REQ-022 SHALL, while rst = 1 at a clock edge, set state to EMPTY, giving out.valid = 0 and in.ready = 1 from the next cycle.
REQ-023 SHALL, on reset mid-beat, drop any buffered, partially emitted beat without further output; buffer data and keep need not be cleared.
REQ-024 SHALL NOT accept an in handshake during a reset cycle.

Configuration
REQ-021 SHALL, with macro LIBSTF_DWC_SKIP_EMPTY_HALF_EN defined, skip the HIGH half when buffered keep[15:8] == 0: LOW becomes final, carries last, and returns to EMPTY or LOW per REQ-017.
REQ-025 SHALL, without LIBSTF_DWC_SKIP_EMPTY_HALF_EN, always emit both halves, including a HIGH half with keep 0, and assert last only on HIGH.
REQ-026 SHALL always emit the LOW half in both configurations, even when keep[7:0] == 0, so that last is never lost.

Verification
REQ-027 SHALL cover a single beat: in data 0..15, keep 0xFFFF, last=1, out.ready=1 -> cycle+1 out data 0..7, keep 0xFF, last 0; cycle+2 data 8..15, keep 0xFF, last 1; then out.valid 0.
REQ-028 SHALL cover streaming: 4 back-to-back beats with in.valid=1 and out.ready=1 -> 8 consecutive out beats with no bubble; in.ready pattern 1,0,1,0...; last only on the 8th.
REQ-029 SHALL cover backpressure: out.ready low for 3 cycles during HIGH -> out data/keep/last unchanged across the stall, in.ready 0; transfer completes on the first ready cycle.
REQ-030 SHALL cover skipping with the macro defined: beat keep 0x00FF, last=1 -> one out beat, keep 0xFF, last 1. Without the macro -> two beats, second with keep 0x00 and last 1.
REQ-031 SHALL cover reset mid-operation: assert rst in HIGH state -> next cycle out.valid 0, in.ready 1; the next beat is emitted starting at its low half with correct data.
REQ-032 SHALL cover an empty final beat: keep 0x0000, last=1, macro defined -> one out beat, keep 0x00, last 1.
